y_calculator: RTL and testbench



---
 rtl/y_calculator_if.sv | 11 +
 rtl/y_calculator.sv | 152 +++++++++++++++
 tb/tb_y_calculator.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/y_calculator_if.sv
// Y-path data bundle for one CORDIC vectoring iteration.
// There is no valid/ready handshake. The master presents y and x_shift every
// cycle. The slave returns y_out exactly one clock later and loads every cycle.
interface y_calculator_if;
  logic [31:0] y;
  logic [31:0] x_shift;
  logic [31:0] y_out;

  modport master (output y, output x_shift, input y_out);
  modport slave  (input y, input x_shift, output y_out);
endinterface

// File: rtl/y_calculator.sv
// One y-path CORDIC iteration: y_out = y - x_shift when y is non-negative,
// y + x_shift when y is negative. The binary32 adder is combinational and
// feeds a single output register.
module y_calculator (
  input  logic           clock,
  input  logic           reset_n,
  y_calculator_if.slave  bus
);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // Operand unpacking; x_shift takes its effective sign from the rotation direction
  logic        sign_a, sign_b;
  logic [7:0]  exp_a, exp_b;
  logic [22:0] frac_a, frac_b;
  logic        nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;

  assign sign_a = bus.y[31];
  assign sign_b = bus.x_shift[31] ^ ~bus.y[31];
  assign exp_a  = bus.y[30:23];
  assign exp_b  = bus.x_shift[30:23];
  assign frac_a = bus.y[22:0];
  assign frac_b = bus.x_shift[22:0];

  // Denormals count as zeros, so a zero exponent alone means zero
  assign zero_a = (exp_a == 8'd0);
  assign zero_b = (exp_b == 8'd0);
  assign nan_a  = (exp_a == 8'hFF) && (frac_a != 23'd0);
  assign nan_b  = (exp_b == 8'hFF) && (frac_b != 23'd0);
  assign inf_a  = (exp_a == 8'hFF) && (frac_a == 23'd0);
  assign inf_b  = (exp_b == 8'hFF) && (frac_b == 23'd0);

  // Order operands by magnitude so the subtraction below never goes negative
  logic        a_larger;
  logic        big_sign;
  logic [7:0]  big_exp, small_exp;
  logic [23:0] big_man, small_man;
  logic        eff_sub;

  assign a_larger  = (bus.y[30:0] >= bus.x_shift[30:0]);
  assign big_sign  = a_larger ? sign_a : sign_b;
  assign big_exp   = a_larger ? exp_a : exp_b;
  assign small_exp = a_larger ? exp_b : exp_a;
  assign big_man   = a_larger ? {1'b1, frac_a} : {1'b1, frac_b};
  assign small_man = a_larger ? {1'b1, frac_b} : {1'b1, frac_a};
  assign eff_sub   = sign_a ^ sign_b;

  // Alignment. Anything shifted past the round bit folds into sticky. A shift
  // of 26 already pushes the whole mantissa into sticky, so larger ones clamp.
  logic [7:0]  exp_diff;
  logic [4:0]  shift_amt;
  logic [49:0] wide;
  logic [26:0] big_ext, small_ext;
  logic [27:0] sum;

  assign exp_diff  = big_exp - small_exp;
  assign shift_amt = (exp_diff > 8'd26) ? 5'd26 : exp_diff[4:0];
  assign wide      = {small_man, 26'd0} >> shift_amt;
  assign big_ext   = {big_man, 3'b000};
  assign small_ext = {wide[49:24], |wide[23:0]};
  assign sum       = eff_sub ? ({1'b0, big_ext} - {1'b0, small_ext})
                             : ({1'b0, big_ext} + {1'b0, small_ext});

  function automatic logic [4:0] lead_zeros(input logic [26:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd27;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 5'(26 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  // Normalization: a carry shifts right by one, cancellation shifts left by the LZC
  logic [4:0]        lz;
  logic [26:0]       norm;
  logic signed [9:0] norm_exp;

  assign lz = lead_zeros(sum[26:0]);

  always_comb begin
    norm     = '0;
    norm_exp = '0;
    if (sum[27]) begin
      norm     = {sum[27:2], sum[1] | sum[0]};
      norm_exp = 10'(big_exp) + 10'sd1;
    end else begin
      norm     = sum[26:0] << lz;
      norm_exp = 10'(big_exp) - 10'(lz);
    end
  end

  // Round to nearest even using guard plus the OR of round and sticky
  logic [23:0]       mant;
  logic              round_up;
  logic [24:0]       mant_r;
  logic signed [9:0] exp_r;
  logic [22:0]       frac_r;

  assign mant     = norm[26:3];
  assign round_up = norm[2] & (norm[1] | norm[0] | mant[0]);
  assign mant_r   = {1'b0, mant} + 25'(round_up);

  always_comb begin
    exp_r  = norm_exp;
    frac_r = mant_r[22:0];
    if (mant_r[24]) begin
      exp_r  = norm_exp + 10'sd1;
      frac_r = mant_r[23:1];
    end
  end

  // Result selection: specials and zeros first, then overflow/underflow of the core path
  logic [31:0] result;

  always_comb begin
    result = {big_sign, exp_r[7:0], frac_r};
    if (nan_a || nan_b) begin
      result = QNAN;
    end else if (inf_a && inf_b) begin
      result = eff_sub ? QNAN : {sign_a, 8'hFF, 23'd0};
    end else if (inf_a) begin
      result = {sign_a, 8'hFF, 23'd0};
    end else if (inf_b) begin
      result = {sign_b, 8'hFF, 23'd0};
    end else if (zero_a && zero_b) begin
      result = {sign_a & sign_b, 31'd0};
    end else if (zero_a) begin
      result = {sign_b, bus.x_shift[30:0]};
    end else if (zero_b) begin
      result = bus.y;
    end else if (sum == 28'd0) begin
      result = 32'd0;
    end else if (exp_r >= 10'sd255) begin
      result = {big_sign, 8'hFF, 23'd0};
    end else if (exp_r <= 10'sd0) begin
      result = 32'd0;
    end
  end

  // Output register loads every cycle; reset clears it and drops the in-flight result
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      bus.y_out <= 32'd0;
    end else begin
      bus.y_out <= result;
    end
  end
endmodule

// File: tb/tb_y_calculator.sv
// Bench for y_calculator. Each driven cycle pushes its expected y_out, which is
// popped and compared one edge later. Random vectors use an exact-integer
// reference model.
module tb_y_calculator;
  logic clock = 1'b0;
  logic reset_n = 1'b0;

  y_calculator_if bus ();

  y_calculator dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Clock/reset block
  always #5 clock = ~clock;

  int          checks_total = 0;
  int          checks_passed = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];
  logic [31:0] last_exp = 32'd0;
  bit          have_last = 1'b0;
  logic [31:0] mon_exp;
  string       mon_tag;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks_total++;
    if (got === want) checks_passed++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, want);
  endtask

  // Exact reference: align both significands to a common integer scale, add,
  // then round the exact sum once to 24 bits with ties-to-even. Valid only for
  // normal operands whose exponents are within 30 and away from the range ends.
  function automatic logic [31:0] ref_y(input logic [31:0] yv, input logic [31:0] xv);
    int     ea, eb, emin, sh, p, e_out;
    longint va, vb, s, mag, q, rem, half;
    logic   rs;
    ea   = int'(yv[30:23]);
    eb   = int'(xv[30:23]);
    emin = (ea < eb) ? ea : eb;
    va   = longint'({1'b1, yv[22:0]}) << (ea - emin);
    vb   = longint'({1'b1, xv[22:0]}) << (eb - emin);
    if (yv[31]) va = -va;
    if (xv[31] ^ ~yv[31]) vb = -vb;
    s = va + vb;
    if (s == 0) return 32'd0;
    rs  = (s < 0);
    mag = rs ? -s : s;
    p   = 0;
    for (int i = 0; i < 63; i++) if (mag[i]) p = i;
    if (p > 23) begin
      sh   = p - 23;
      q    = mag >> sh;
      rem  = mag - (q << sh);
      half = 64'sd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == (64'sd1 << 24)) begin
        q  = q >> 1;
        sh = sh + 1;
      end
      e_out = emin + sh;
    end else begin
      q     = mag << (23 - p);
      e_out = emin - (23 - p);
    end
    return {rs, 8'(e_out), q[22:0]};
  endfunction

  // Driver: inputs change on the falling edge; the value registered at the
  // previous rising edge must still be on y_out at this point.
  task automatic drive(input string tag, input logic rst_n, input logic [31:0] yv,
                       input logic [31:0] xv, input logic [31:0] want);
    @(negedge clock);
    if (have_last) check("hold", bus.y_out, last_exp);
    reset_n     = rst_n;
    bus.y       = yv;
    bus.x_shift = xv;
    exp_q.push_back(rst_n ? want : 32'd0);
    tag_q.push_back(tag);
  endtask

  // Scoreboard: one result per rising edge while entries are pending
  always @(posedge clock) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_tag = tag_q.pop_front();
      check(mon_tag, bus.y_out, mon_exp);
      last_exp  = mon_exp;
      have_last = 1'b1;
    end
  end

  initial begin
    logic [31:0] ry, rx;
    int          ea, eb;
    logic        rr;
    bus.y       = 32'd0;
    bus.x_shift = 32'd0;

    // Reset held for two cycles with live data on the inputs
    drive("reset_a", 1'b0, 32'h3F80_0000, 32'h3F00_0000, 32'd0);
    drive("reset_b", 1'b0, 32'h4A00_0005, 32'h3F80_0000, 32'd0);

    // Directed vectors; the first result lands one edge after reset release
    drive("tiny_sub",    1'b1, 32'h3000_0000, 32'h0A00_0000, 32'h3000_0000);
    drive("neg_y_dom_x", 1'b1, 32'hA100_0000, 32'h4A00_0005, 32'h4A00_0005);
    drive("denorm_x",    1'b1, 32'h026E_8B75, 32'h0000_0003, 32'h026E_8B75);
    drive("one_m_half",  1'b1, 32'h3F80_0000, 32'h3F00_0000, 32'h3F00_0000);
    drive("neg_add",     1'b1, 32'hBF80_0000, 32'h3F00_0000, 32'hBF00_0000);
    drive("cancel",      1'b1, 32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000);
    // 1 - 2^-24 is exactly representable (the ulp below 1.0 is 2^-24)
    drive("one_m_ulp",   1'b1, 32'h3F80_0000, 32'h3380_0000, 32'h3F7F_FFFF);
    // 1 + 2^-24 is a true halfway case: ties to even stays at 1.0
    drive("tie_even",    1'b1, 32'h3F80_0000, 32'hB380_0000, 32'h3F80_0000);
    drive("tie_odd",     1'b1, 32'h3F80_0001, 32'hB380_0000, 32'h3F80_0002);
    drive("inf_m_inf",   1'b1, 32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000);
    drive("overflow",    1'b1, 32'h7F7F_FFFF, 32'hFF7F_FFFF, 32'h7F80_0000);

    // Mid-stream reset drops the in-flight result, then data resumes
    drive("mid_reset",   1'b0, 32'h4000_0000, 32'h3F80_0000, 32'd0);
    drive("after_reset", 1'b1, 32'hC000_0000, 32'hBF80_0000, 32'hC040_0000);
    drive("nan_y",       1'b1, 32'h7FC1_2345, 32'h3F80_0000, 32'h7FC0_0000);
    drive("nan_x",       1'b1, 32'h3F80_0000, 32'hFFFF_FFFF, 32'h7FC0_0000);
    drive("fin_m_inf",   1'b1, 32'h3F80_0000, 32'h7F80_0000, 32'hFF80_0000);
    drive("zero_y_pass", 1'b1, 32'h0000_0000, 32'h4000_0000, 32'hC000_0000);
    drive("pz_m_pz",     1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000);
    drive("nz_p_nz",     1'b1, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
    drive("underflow",   1'b1, 32'h0080_0001, 32'h0080_0000, 32'h0000_0000);

    // Random normals with nearby exponents and an occasional reset cycle
    for (int n = 0; n < 200; n++) begin
      ea = $urandom_range(60, 190);
      eb = ea + $urandom_range(0, 60) - 30;
      ry = {1'($urandom_range(0, 1)), 8'(ea), 23'($urandom)};
      rx = {1'($urandom_range(0, 1)), 8'(eb), 23'($urandom)};
      if ($urandom_range(0, 7) == 0) rx[30:0] = ry[30:0];
      rr = ($urandom_range(0, 15) != 0);
      drive("random", rr, ry, rx, ref_y(ry, rx));
    end

    repeat (3) @(negedge clock);
    check("drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule
